// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter and other BRAM clients:
// FSM encodings, requester ids and default bus widths.
package bram_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arbState_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    arbState_t state;
    logic      rrPtr;
  } arbDbg_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// One requester's view of the shared BRAM port.
// Handshake: req (with lock/we/addr/wdata) is held until gnt; a beat is a
// cycle with req & gnt. rvalid qualifies rdata for exactly one cycle.
interface bram_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              req;
  logic              lock;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// DEPTH-stage {valid,port} shift register that tracks outstanding BRAM reads
// so returning data can be steered to the requester that issued it.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inValid,
  input  logic inPort,
  output logic outValid,
  output logic outPort
);
  logic [DEPTH-1:0] validPipe;
  logic [DEPTH-1:0] portPipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validPipe <= '0;
      portPipe  <= '0;
    end else begin
      validPipe[0] <= inValid;
      portPipe[0]  <= inPort;
      for (int i = 1; i < DEPTH; i++) begin
        validPipe[i] <= validPipe[i-1];
        portPipe[i]  <= portPipe[i-1];
      end
    end
  end

  assign outValid = validPipe[DEPTH-1];
  assign outPort  = portPipe[DEPTH-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the EPP bridge (A) and the
// acquisition engine (B), with lockable bursts capped under contention.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_port_arbiter_if.slave portA,
  bram_port_arbiter_if.slave portB,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output arbDbg_t           dbg
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

  arbState_t        state;
  logic             rrPtr;
  logic [CNT_W-1:0] beatCnt;
  logic             ownA, ownB, beat, rdBeat, issuePort;
  logic             relA, relB, tagValid, tagPort;

  assign ownA      = (state == OWN_A);
  assign ownB      = (state == OWN_B);
  assign portA.gnt = ownA & portA.req;
  assign portB.gnt = ownB & portB.req;
  assign beat      = portA.gnt | portB.gnt;

  // Owner gives up the port when idle, when unlocked and contested, or at the burst cap.
  assign relA = !portA.req || (portB.req && (!portA.lock || beatCnt == CAP));
  assign relB = !portB.req || (portA.req && (!portB.lock || beatCnt == CAP));

  always_comb begin
    bram_en   = beat;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (ownA) begin
      bram_we   = portA.we & portA.req;
      bram_addr = portA.addr;
      bram_din  = portA.wdata;
    end else if (ownB) begin
      bram_we   = portB.we & portB.req;
      bram_addr = portB.addr;
      bram_din  = portB.wdata;
    end
  end

  assign rdBeat    = beat & ~bram_we;
  assign issuePort = ownB ? PORT_B : PORT_A;

  rd_tag_pipe #(.DEPTH(RD_LAT)) uTagPipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (rdBeat),
    .inPort   (issuePort),
    .outValid (tagValid),
    .outPort  (tagPort)
  );

  // BRAM output register is the capture stage; data is gated to the tagged cycle.
  assign portA.rvalid = tagValid & (tagPort == PORT_A);
  assign portB.rvalid = tagValid & (tagPort == PORT_B);
  assign portA.rdata  = tagValid ? bram_dout : '0;
  assign portB.rdata  = tagValid ? bram_dout : '0;

  assign dbg.state = state;
  assign dbg.rrPtr = rrPtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rrPtr   <= PORT_A;
      beatCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          beatCnt <= '0;
          if (portA.req && (!portB.req || rrPtr == PORT_A)) state <= OWN_A;
          else if (portB.req)                               state <= OWN_B;
        end
        OWN_A: begin
          if (relA) begin
            state   <= portB.req ? OWN_B : IDLE;
            rrPtr   <= PORT_B;
            beatCnt <= '0;
          end else if (beatCnt != CAP) begin
            beatCnt <= beatCnt + CNT_W'(1);
          end
        end
        OWN_B: begin
          if (relB) begin
            state   <= portA.req ? OWN_A : IDLE;
            rrPtr   <= PORT_A;
            beatCnt <= '0;
          end else if (beatCnt != CAP) begin
            beatCnt <= beatCnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          beatCnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: one instance with RD_LAT=1 for the
// arbitration/data tests and one with RD_LAT=3 for reset with reads in flight.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1_n, rst3_n;

  int errors = 0;
  int checks = 0;

  bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) a1 ();
  bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) b1 ();
  bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) a3 ();
  bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) b3 ();

  logic        en1, we1, en3, we3;
  logic [11:0] addr1, addr3;
  logic [7:0]  din1, dout1, din3, dout3;
  arbDbg_t     dbg1, dbg3;

  bram_port_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(1), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst1_n), .portA(a1), .portB(b1),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_din(din1),
    .bram_dout(dout1), .dbg(dbg1)
  );

  bram_port_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(3), .MAX_BURST(16)) dutL (
    .clk(clk), .rst_n(rst3_n), .portA(a3), .portB(b3),
    .bram_en(en3), .bram_we(we3), .bram_addr(addr3), .bram_din(din3),
    .bram_dout(dout3), .dbg(dbg3)
  );

  // ---------------- BRAM models ----------------
  // Unwritten locations read as addr[7:0]+0x90, so 0x010..0x013 hold 0xA0..0xA3.
  function automatic logic [7:0] initVal(input logic [11:0] a);
    return a[7:0] + 8'h90;
  endfunction

  logic [7:0] mem1 [0:4095];
  bit         wr1  [0:4095];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (en1) begin
      if (we1) begin
        mem1[addr1] <= din1;
        wr1[addr1]  <= 1'b1;
      end else begin
        rd1 <= wr1[addr1] ? mem1[addr1] : initVal(addr1);
      end
    end
  end
  assign dout1 = rd1;

  logic [7:0] mem3 [0:4095];
  bit         wr3  [0:4095];
  logic [7:0] p0, p1, p2;
  always @(posedge clk) begin
    if (en3 && we3) begin
      mem3[addr3] <= din3;
      wr3[addr3]  <= 1'b1;
    end
    if (en3 && !we3) p0 <= wr3[addr3] ? mem3[addr3] : initVal(addr3);
    p1 <= p0;
    p2 <= p1;
  end
  assign dout3 = p2;

  // ---------------- driver tasks ----------------
  task automatic drvA1(input logic req, input logic lock, input logic we,
                       input logic [11:0] addr, input logic [7:0] wd);
    a1.req = req; a1.lock = lock; a1.we = we; a1.addr = addr; a1.wdata = wd;
  endtask

  task automatic drvB1(input logic req, input logic lock, input logic we,
                       input logic [11:0] addr, input logic [7:0] wd);
    b1.req = req; b1.lock = lock; b1.we = we; b1.addr = addr; b1.wdata = wd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle1(input string tag);
    chk({tag, "_agnt"},  a1.gnt, 0);
    chk({tag, "_bgnt"},  b1.gnt, 0);
    chk({tag, "_arv"},   a1.rvalid, 0);
    chk({tag, "_brv"},   b1.rvalid, 0);
    chk({tag, "_en"},    en1, 0);
    chk({tag, "_we"},    we1, 0);
    chk({tag, "_addr"},  addr1, 0);
    chk({tag, "_din"},   din1, 0);
    chk({tag, "_rdata"}, a1.rdata, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- burst bookkeeping ----------------
  int   aBeats, idleCyc, nRuns;
  logic runPort [8];
  int   runLen  [8];
  logic expPort [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   expLen  [5] = '{16, 1, 16, 1, 8};
  logic p;

  // ---------------- directed sequence ----------------
  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    drvA1(0, 0, 0, 0, 0); drvB1(0, 0, 0, 0, 0);
    a3.req = 0; a3.lock = 0; a3.we = 0; a3.addr = 0; a3.wdata = 0;
    b3.req = 0; b3.lock = 0; b3.we = 0; b3.addr = 0; b3.wdata = 0;
    for (int k = 0; k < 8; k++) begin runPort[k] = 1'b0; runLen[k] = 0; end

    repeat (2) @(negedge clk);
    #1;
    chkIdle1("rst");
    chk("rst_state", dbg1.state, IDLE);
    chk("rst_rr", dbg1.rrPtr, PORT_A);
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;

    // Test 1: A alone, four reads 0x010..0x013
    @(negedge clk); drvA1(1, 0, 0, 12'h010, 0); #1;
    chk("t1_idle_gnt", a1.gnt, 0);
    chk("t1_idle_en", en1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drvA1(1, 0, 0, 12'(12'h010 + i), 0); #1;
      chk("t1_gnt", a1.gnt, 1);
      chk("t1_en", en1, 1);
      chk("t1_we", we1, 0);
      chk("t1_addr", addr1, 32'(12'h010 + i));
      if (i == 0) chk("t1_rv0", a1.rvalid, 0);
      else begin
        chk("t1_rv", a1.rvalid, 1);
        chk("t1_rdata", a1.rdata, 32'(8'hA0 + i - 1));
      end
    end
    @(negedge clk); drvA1(0, 0, 0, 12'h013, 0); #1;
    chk("t1_drop_gnt", a1.gnt, 0);
    chk("t1_drop_en", en1, 0);
    chk("t1_last_rv", a1.rvalid, 1);
    chk("t1_last_rdata", a1.rdata, 8'hA3);
    @(negedge clk); #1;
    chk("t1_rv_end", a1.rvalid, 0);
    chk("t1_state", dbg1.state, IDLE);
    chk("t1_rr", dbg1.rrPtr, PORT_B);

    // Test 4: A writes 0x5C to 0x0FF, then B reads it back
    @(negedge clk); drvA1(1, 0, 1, 12'h0FF, 8'h5C); #1;
    chk("t4_idle_gnt", a1.gnt, 0);
    @(negedge clk); #1;
    chk("t4_wgnt", a1.gnt, 1);
    chk("t4_we", we1, 1);
    chk("t4_waddr", addr1, 12'h0FF);
    chk("t4_wdin", din1, 8'h5C);
    @(negedge clk); drvA1(0, 0, 0, 0, 0); drvB1(1, 0, 0, 12'h0FF, 0); #1;
    chk("t4_handover_en", en1, 0);
    chk("t4_handover_bgnt", b1.gnt, 0);
    chk("t4_arv_a", a1.rvalid, 0);
    @(negedge clk); #1;
    chk("t4_bgnt", b1.gnt, 1);
    chk("t4_raddr", addr1, 12'h0FF);
    chk("t4_rwe", we1, 0);
    chk("t4_arv_b", a1.rvalid, 0);
    @(negedge clk); drvB1(0, 0, 0, 0, 0); #1;
    chk("t4_brv", b1.rvalid, 1);
    chk("t4_rdata", b1.rdata, 8'h5C);
    chk("t4_arv_c", a1.rvalid, 0);
    @(negedge clk); #1;
    chk("t4_brv_end", b1.rvalid, 0);
    chk("t4_state", dbg1.state, IDLE);
    chk("t4_rr", dbg1.rrPtr, PORT_A);

    // Test 6: B requests, then withdraws before it is granted
    @(negedge clk); drvB1(1, 0, 0, 12'h123, 0); #1;
    chk("t6_gnt0", b1.gnt, 0);
    chk("t6_en0", en1, 0);
    @(negedge clk); drvB1(0, 0, 0, 12'h123, 0); #1;
    chk("t6_state_ownb", dbg1.state, OWN_B);
    chk("t6_gnt1", b1.gnt, 0);
    chk("t6_en1", en1, 0);
    @(negedge clk); drvA1(1, 0, 0, 12'h001, 0); drvB1(1, 0, 0, 12'h002, 0); #1;
    chk("t6_state_idle", dbg1.state, IDLE);
    chk("t6_rr", dbg1.rrPtr, PORT_A);
    @(negedge clk); #1;
    chk("t6_agnt", a1.gnt, 1);
    chk("t6_bgnt_lo", b1.gnt, 0);
    @(negedge clk); #1;
    chk("t6_bgnt", b1.gnt, 1);
    chk("t6_agnt_lo", a1.gnt, 0);
    @(negedge clk); drvA1(0, 0, 0, 0, 0); drvB1(0, 0, 0, 0, 0);

    // Test 2: both request out of reset, unlocked single beats alternate
    rst1_n = 1'b0; #1;
    chkIdle1("t2_rst");
    @(negedge clk); rst1_n = 1'b1;
    @(negedge clk); drvA1(1, 0, 0, 12'h040, 0); drvB1(1, 0, 0, 12'h080, 0); #1;
    chk("t2_idle_agnt", a1.gnt, 0);
    chk("t2_idle_bgnt", b1.gnt, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t2_agnt", a1.gnt, (i % 2 == 0));
      chk("t2_bgnt", b1.gnt, (i % 2 == 1));
      chk("t2_en", en1, 1);
      chk("t2_addr", addr1, (i % 2 == 0) ? 12'h040 : 12'h080);
    end
    @(negedge clk); drvA1(0, 0, 0, 0, 0); drvB1(0, 0, 0, 0, 0);
    rst1_n = 1'b0;
    @(negedge clk); rst1_n = 1'b1;

    // Test 3: locked 40-beat A burst against a persistent B request
    aBeats = 0; idleCyc = 0; nRuns = 0;
    for (int c = 0; c < 200 && aBeats < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drvA1(1, 1, 0, 12'h200, 0);
        drvB1(1, 0, 0, 12'h300, 0);
      end
      #1;
      if (a1.gnt || b1.gnt) begin
        p = b1.gnt;
        if (a1.gnt) aBeats++;
        if (nRuns == 0 || runPort[nRuns-1] != p) begin
          if (nRuns < 8) begin runPort[nRuns] = p; runLen[nRuns] = 1; end
          nRuns++;
        end else if (nRuns <= 8) begin
          runLen[nRuns-1]++;
        end
      end else begin
        idleCyc++;
      end
    end
    @(negedge clk); drvA1(0, 0, 0, 0, 0); drvB1(0, 0, 0, 0, 0);
    chk("t3_a_beats", aBeats, 40);
    chk("t3_idle_cycles", idleCyc, 1);
    chk("t3_runs", nRuns, 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_run_port", runPort[k], expPort[k]);
      chk("t3_run_len", runLen[k], expLen[k]);
    end

    // Test 5: reset with two RD_LAT=3 reads outstanding
    @(negedge clk); a3.req = 1; a3.addr = 12'h020; #1;
    chk("t5_idle_gnt", a3.gnt, 0);
    @(negedge clk); #1;
    chk("t5_gnt0", a3.gnt, 1);
    chk("t5_en0", en3, 1);
    @(negedge clk); a3.addr = 12'h021; #1;
    chk("t5_gnt1", a3.gnt, 1);
    chk("t5_rv_early", a3.rvalid, 0);
    @(negedge clk); a3.req = 0; rst3_n = 1'b0; #1;
    chk("t5_rst_agnt", a3.gnt, 0);
    chk("t5_rst_en", en3, 0);
    chk("t5_rst_we", we3, 0);
    chk("t5_rst_addr", addr3, 0);
    chk("t5_rst_din", din3, 0);
    chk("t5_rst_rdata", a3.rdata, 0);
    chk("t5_rst_state", dbg3.state, IDLE);
    @(negedge clk); rst3_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t5_no_arv", a3.rvalid, 0);
      chk("t5_no_brv", b3.rvalid, 0);
    end
    @(negedge clk); a3.req = 1; a3.addr = 12'h030; b3.req = 1; b3.addr = 12'h031; #1;
    chk("t5_idle_agnt", a3.gnt, 0);
    chk("t5_rr", dbg3.rrPtr, PORT_A);
    @(negedge clk); #1;
    chk("t5_agnt", a3.gnt, 1);
    chk("t5_bgnt", b3.gnt, 0);
    @(negedge clk); a3.req = 0; b3.req = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
